// File: rtl/shift_pkg.sv
// Shared types and default sizing for the iterative left shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_IDLE,
    SHIFT_RUN,
    SHIFT_DONE
  } shift_state_e;

  localparam int SHIFT_WIDTH     = 32;
  localparam int SHIFT_AMT_WIDTH = 5;
  localparam int SHIFT_STEP      = 4;

endpackage

// File: rtl/shift_left_step.sv
// Combinational left shift by 0..STEP bits, vacated LSBs take the fill bit.
// Zero latency; no flow control.
module shift_left_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [KW-1:0]    i_k,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_cand [STEP+1];

  assign w_cand[0] = i_data;

  for (genvar j = 1; j <= STEP; j++) begin : g_cand
    if (j < WIDTH) begin : g_part
      assign w_cand[j] = {i_data[WIDTH-1-j:0], {j{i_fill}}};
    end else begin : g_all
      assign w_cand[j] = {WIDTH{i_fill}};
    end
  end

  always_comb begin
    o_data = w_cand[0];
    for (int j = 1; j <= STEP; j++) begin
      if (i_k == KW'(j)) o_data = w_cand[j];
    end
  end

endmodule

// File: rtl/shift_left_iterative.sv
// Multi-cycle left shifter: up to STEP bits per clock, 1 + ceil(N/STEP) cycles from accept to out_valid.
// Single request in flight; result held until out_ready, no accept in the handshake cycle.
module shift_left_iterative
  import shift_pkg::*;
#(
  parameter int WIDTH     = SHIFT_WIDTH,
  parameter int AMT_WIDTH = SHIFT_AMT_WIDTH,
  parameter int STEP      = SHIFT_STEP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [AMT_WIDTH-1:0] in_amount,
  input  logic                 in_fill,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data
);

  localparam int                 KW     = $clog2(STEP + 1);
  localparam logic [AMT_WIDTH:0] STEP_W = (AMT_WIDTH + 1)'(STEP);

  shift_state_e         r_state;
  logic [WIDTH-1:0]     r_work;
  logic [AMT_WIDTH-1:0] r_remaining;
  logic                 r_fill;
  logic                 r_out_valid;

  logic [AMT_WIDTH:0]   w_k;
  logic [AMT_WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0]     w_shifted;

  // One extra bit so STEP == WIDTH still compares correctly against remaining.
  assign w_k        = ({1'b0, r_remaining} > STEP_W) ? STEP_W : {1'b0, r_remaining};
  assign w_rem_next = r_remaining - w_k[AMT_WIDTH-1:0];

  shift_left_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .i_data (r_work),
    .i_k    (KW'(w_k)),
    .i_fill (r_fill),
    .o_data (w_shifted)
  );

  assign in_ready  = (r_state == SHIFT_IDLE) && rst_n;
  assign out_valid = r_out_valid;
  assign out_data  = r_work;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SHIFT_IDLE;
      r_work      <= '0;
      r_remaining <= '0;
      r_fill      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        SHIFT_IDLE: begin
          if (in_valid) begin
            r_work      <= in_data;
            r_remaining <= in_amount;
            r_fill      <= in_fill;
            if (in_amount == '0) begin
              r_state     <= SHIFT_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= SHIFT_RUN;
            end
          end
        end
        SHIFT_RUN: begin
          r_work      <= w_shifted;
          r_remaining <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state     <= SHIFT_DONE;
            r_out_valid <= 1'b1;
          end
        end
        SHIFT_DONE: begin
          if (out_ready) begin
            r_state     <= SHIFT_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= SHIFT_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_left_iterative.sv
// Directed bench for shift_left_iterative: values, latency, backpressure, reset abort, back-to-back.
module tb_shift_left_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amount;
  logic        in_fill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_left_iterative dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_fill   (in_fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a request and returns just after the accept edge.
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic f);
    int t = 0;
    in_data   = d;
    in_amount = a;
    in_fill   = f;
    in_valid  = 1'b1;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; latency 1 means out_valid is already up.
  task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat,
                             output int busy_hits);
    int lat = 1;
    busy_hits = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_hits++;
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, out_data, exp);
    check({tag, "_rdy_in_done"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_released"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] d, input logic [4:0] a, input logic f,
                     input logic [31:0] exp, input int exp_lat);
    int busy;
    send(d, a, f);
    wait_result(tag, exp, exp_lat, busy);
    release_result(tag);
  endtask

  initial begin
    int busy;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amount = '0;
    in_fill   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0000_0000);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Zero shift, maximum shift, partial step with fill
    run("zero", 32'h0000_0001, 5'd0, 1'b0, 32'h0000_0001, 1);
    send(32'h8000_0001, 5'd31, 1'b0);
    wait_result("max", 32'h8000_0000, 9, busy);
    check("max_busy_ready", 32'(busy), 32'd0);
    release_result("max");
    run("fill5", 32'h0000_00FF, 5'd5, 1'b1, 32'h0000_1FFF, 3);
    run("exact_step", 32'h0F0F_0F0F, 5'd4, 1'b0, 32'hF0F0_F0F0, 2);
    run("one_fill", 32'h8000_0000, 5'd1, 1'b1, 32'h0000_0001, 2);
    run("half_fill", 32'hA5A5_A5A5, 5'd16, 1'b1, 32'hA5A5_FFFF, 5);

    // Backpressure with a competing request that must not be captured
    send(32'h0000_00FF, 5'd5, 1'b1);
    wait_result("bp", 32'h0000_1FFF, 3, busy);
    in_data   = 32'hDEAD_BEEF;
    in_amount = 5'd0;
    in_fill   = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", out_data, 32'h0000_1FFF);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_result("bp");
    check("bp_not_captured", out_data, 32'h0000_1FFF);
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);

    // Reset after two shift edges of a 20-bit shift
    send(32'h0000_0001, 5'd20, 1'b0);
    step();
    step();
    check("mid_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_out_data", out_data, 32'h0000_0000);
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    run("after_rst", 32'h0000_0001, 5'd4, 1'b0, 32'h0000_0010, 2);

    // Back-to-back: next request offered in the output handshake cycle
    send(32'h1234_5678, 5'd8, 1'b0);
    wait_result("b2b_a", 32'h3456_7800, 3, busy);
    in_data   = 32'h0000_000F;
    in_amount = 5'd3;
    in_fill   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("b2b_handshake_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_ready_after_hs", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("b2b_accepted", {31'd0, in_ready}, 32'd0);
    wait_result("b2b_b", 32'h0000_007F, 2, busy);
    release_result("b2b_b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
